// File: rtl/scfifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package scfifo_pkg;

   localparam string SC_YES = "Y";
   localparam string SC_NO  = "N";

   function automatic int usedw_width(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: one synchronous write port, one read port that is
// combinational (REGOUT="N") or registered (REGOUT="Y"); no backpressure.
module dpram
   import scfifo_pkg::*;
#(
   parameter int    DWIDTH = 16,
   parameter int    AWIDTH = 5,
   parameter string REGOUT = SC_NO
) (
   input  logic              i_clk,
   input  logic              i_wren,
   input  logic [AWIDTH-1:0] i_wraddr,
   input  logic [DWIDTH-1:0] i_wdat,
   input  logic [AWIDTH-1:0] i_rdaddr,
   output logic [DWIDTH-1:0] o_rdat
);

   logic [DWIDTH-1:0] r_mem [2**AWIDTH];

   always_ff @(posedge i_clk) begin
      if (i_wren) r_mem[i_wraddr] <= i_wdat;
   end

   generate
      if (REGOUT == SC_YES) begin : g_regout
         logic [DWIDTH-1:0] r_rdat;
         always_ff @(posedge i_clk) begin
            r_rdat <= r_mem[i_rdaddr];
         end
         assign o_rdat = r_rdat;
      end else begin : g_combout
         assign o_rdat = r_mem[i_rdaddr];
      end
   endgenerate

endmodule

// File: rtl/scfifo_ext.sv
// Single-clock FIFO, any depth, normal (q 1 cycle after read) or show-ahead mode.
// Protected mode drops writes when full / reads when empty; ovf/unf record such attempts.
module scfifo_ext
   import scfifo_pkg::*;
#(
   parameter int    WIDTH     = 16,
   parameter int    SIZE      = 32,
   parameter string SHOWAHEAD = SC_NO,
   parameter string PROTECTED = SC_YES,
   parameter int    AFULL     = SIZE - 2,
   parameter int    AEMPTY    = 2,
   parameter int    AWIDTH    = $clog2(SIZE),
   parameter int    UWIDTH    = usedw_width(SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclr,
   input  logic [WIDTH-1:0]  data,
   input  logic              write,
   input  logic              read,
   output logic [WIDTH-1:0]  q,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [UWIDTH-1:0] usedw,
   output logic              ovf,
   output logic              unf
);

   localparam bit                SA      = (SHOWAHEAD == SC_YES);
   localparam bit                PROT    = (PROTECTED == SC_YES);
   localparam logic [AWIDTH-1:0] P_LAST  = AWIDTH'(SIZE - 1);
   localparam logic [UWIDTH-1:0] U_SIZE  = UWIDTH'(SIZE);
   localparam logic [UWIDTH-1:0] U_AFULL = UWIDTH'(AFULL);
   localparam logic [UWIDTH-1:0] U_AEMPT = UWIDTH'(AEMPTY);

   if (SIZE < 4) begin : g_size_chk
      $error("scfifo_ext: SIZE must be >= 4");
   end
   if (AFULL < 0 || AFULL > SIZE) begin : g_afull_chk
      $error("scfifo_ext: AFULL outside 0..SIZE");
   end
   if (AEMPTY < 0 || AEMPTY > SIZE) begin : g_aempty_chk
      $error("scfifo_ext: AEMPTY outside 0..SIZE");
   end

   logic [AWIDTH-1:0] r_wrptr, r_rdptr;
   logic [UWIDTH-1:0] r_usedw;
   logic [WIDTH-1:0]  r_q;
   logic              r_qv, r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;

   logic              w_writep, w_readp, w_pref, w_mem_rd, w_qv_nxt;
   logic [UWIDTH-1:0] w_scnt, w_usedw_nxt;
   logic [WIDTH-1:0]  w_rd_dat;

   function automatic logic [AWIDTH-1:0] ptr_inc(input logic [AWIDTH-1:0] p);
      return (p == P_LAST) ? '0 : p + AWIDTH'(1);
   endfunction

   assign w_writep    = PROT ? (write && !r_full) : write;
   assign w_readp     = PROT ? (read && !r_empty) : read;
   assign w_usedw_nxt = r_usedw + UWIDTH'(w_writep) - UWIDTH'(w_readp);

   // Show-ahead: the output register holds one counted word; storage refills it
   // whenever it is empty or being popped and storage has something.
   assign w_scnt   = r_usedw - UWIDTH'(r_qv);
   assign w_pref   = (w_scnt != '0) && (!r_qv || w_readp);
   assign w_qv_nxt = w_pref ? 1'b1 : (w_readp ? 1'b0 : r_qv);
   assign w_mem_rd = SA ? w_pref : w_readp;

   dpram #(
      .DWIDTH (WIDTH),
      .AWIDTH (AWIDTH),
      .REGOUT (SC_NO)
   ) u_mem (
      .i_clk    (clk),
      .i_wren   (w_writep),
      .i_wraddr (r_wrptr),
      .i_wdat   (data),
      .i_rdaddr (r_rdptr),
      .o_rdat   (w_rd_dat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrptr  <= '0;
         r_rdptr  <= '0;
         r_usedw  <= '0;
         r_q      <= '0;
         r_qv     <= 1'b0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= (AFULL == 0);
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else if (sclr) begin
         r_wrptr  <= '0;
         r_rdptr  <= '0;
         r_usedw  <= '0;
         r_qv     <= 1'b0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= (AFULL == 0);
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_writep) r_wrptr <= ptr_inc(r_wrptr);
         if (w_mem_rd) begin
            r_rdptr <= ptr_inc(r_rdptr);
            r_q     <= w_rd_dat;
         end
         r_usedw  <= w_usedw_nxt;
         r_qv     <= SA && w_qv_nxt;
         r_full   <= (w_usedw_nxt == U_SIZE);
         r_empty  <= SA ? !w_qv_nxt : (w_usedw_nxt == '0);
         r_afull  <= (w_usedw_nxt >= U_AFULL);
         r_aempty <= (w_usedw_nxt <= U_AEMPT);
         if (write && r_full)  r_ovf <= 1'b1;
         if (read  && r_empty) r_unf <= 1'b1;
      end
   end

   assign q            = r_q;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign usedw        = r_usedw;
   assign ovf          = r_ovf;
   assign unf          = r_unf;

endmodule

// File: tb/tb_scfifo_ext.sv
// Directed bench for scfifo_ext: SIZE=5 and SIZE=8 normal-mode and SIZE=8 show-ahead instances.
module tb_scfifo_ext;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // SIZE=5 normal, AFULL=3
   logic        n5_sclr = 0, n5_write = 0, n5_read = 0;
   logic [15:0] n5_data = '0, n5_q;
   logic        n5_full, n5_empty, n5_afull, n5_aempty, n5_ovf, n5_unf;
   logic [2:0]  n5_usedw;

   // SIZE=8 normal
   logic        n8_sclr = 0, n8_write = 0, n8_read = 0;
   logic [15:0] n8_data = '0, n8_q;
   logic        n8_full, n8_empty, n8_afull, n8_aempty, n8_ovf, n8_unf;
   logic [3:0]  n8_usedw;

   // SIZE=8 show-ahead
   logic        sa_sclr = 0, sa_write = 0, sa_read = 0;
   logic [15:0] sa_data = '0, sa_q;
   logic        sa_full, sa_empty, sa_afull, sa_aempty, sa_ovf, sa_unf;
   logic [3:0]  sa_usedw;

   scfifo_ext #(.WIDTH(16), .SIZE(5), .AFULL(3)) u_n5 (
      .clk(clk), .rst(rst), .sclr(n5_sclr), .data(n5_data), .write(n5_write), .read(n5_read),
      .q(n5_q), .full(n5_full), .empty(n5_empty), .almost_full(n5_afull),
      .almost_empty(n5_aempty), .usedw(n5_usedw), .ovf(n5_ovf), .unf(n5_unf));

   scfifo_ext #(.WIDTH(16), .SIZE(8)) u_n8 (
      .clk(clk), .rst(rst), .sclr(n8_sclr), .data(n8_data), .write(n8_write), .read(n8_read),
      .q(n8_q), .full(n8_full), .empty(n8_empty), .almost_full(n8_afull),
      .almost_empty(n8_aempty), .usedw(n8_usedw), .ovf(n8_ovf), .unf(n8_unf));

   scfifo_ext #(.WIDTH(16), .SIZE(8), .SHOWAHEAD("Y")) u_sa (
      .clk(clk), .rst(rst), .sclr(sa_sclr), .data(sa_data), .write(sa_write), .read(sa_read),
      .q(sa_q), .full(sa_full), .empty(sa_empty), .almost_full(sa_afull),
      .almost_empty(sa_aempty), .usedw(sa_usedw), .ovf(sa_ovf), .unf(sa_unf));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_chk++; if (n5_usedw !== 3'd0) begin n_fail++; $display("FAIL rst_n5_usedw: got %0d want 0", n5_usedw); end
      n_chk++; if (n5_empty !== 1'b1 || n5_full !== 1'b0) begin n_fail++; $display("FAIL rst_n5_empty_full: got %b%b want 10", n5_empty, n5_full); end
      n_chk++; if (n5_aempty !== 1'b1 || n5_afull !== 1'b0) begin n_fail++; $display("FAIL rst_n5_ae_af: got %b%b want 10", n5_aempty, n5_afull); end
      n_chk++; if (n5_ovf !== 1'b0 || n5_unf !== 1'b0) begin n_fail++; $display("FAIL rst_n5_ovf_unf: got %b%b want 00", n5_ovf, n5_unf); end
      n_chk++; if (n5_q !== 16'h0) begin n_fail++; $display("FAIL rst_n5_q: got %h want 0000", n5_q); end
      n_chk++; if (sa_empty !== 1'b1 || sa_usedw !== 4'd0 || sa_q !== 16'h0) begin n_fail++; $display("FAIL rst_sa: got e=%b u=%0d q=%h want e=1 u=0 q=0000", sa_empty, sa_usedw, sa_q); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_normal_fill_drain();
      for (int i = 0; i < 5; i++) begin
         n5_data = 16'(16'h0011 + i); n5_write = 1'b1;
         tick();
         n_chk++; if (n5_usedw !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_usedw[%0d]: got %0d want %0d", i, n5_usedw, i + 1); end
         n_chk++; if (n5_full !== (i == 4)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, n5_full, (i == 4)); end
         n_chk++; if (n5_afull !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, n5_afull, (i + 1 >= 3)); end
         n_chk++; if (n5_aempty !== (i + 1 <= 2) || n5_empty !== 1'b0) begin n_fail++; $display("FAIL fill_aempty_empty[%0d]: got %b%b want %b0", i, n5_aempty, n5_empty, (i + 1 <= 2)); end
      end
      n5_write = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n5_read = 1'b1;
         tick();
         n_chk++; if (n5_q !== 16'(16'h0011 + i)) begin n_fail++; $display("FAIL drain_q[%0d]: got %h want %h", i, n5_q, 16'(16'h0011 + i)); end
         n_chk++; if (n5_usedw !== 3'(4 - i) || n5_empty !== (i == 4)) begin n_fail++; $display("FAIL drain_usedw[%0d]: got u=%0d e=%b want u=%0d e=%b", i, n5_usedw, n5_empty, 4 - i, (i == 4)); end
      end
      n5_read = 1'b0;
      tick();
      n_chk++; if (n5_q !== 16'h0015 || n5_unf !== 1'b0) begin n_fail++; $display("FAIL drain_hold: got q=%h unf=%b want q=0015 unf=0", n5_q, n5_unf); end
   endtask

   task automatic test_wraparound();
      int wseq = 0;
      int rexp = 0;
      for (int r = 0; r < 4; r++) begin
         for (int s = 0; s < 5; s++) begin
            if (s == 2 || s == 4) begin
               n5_read = 1'b1; n5_write = 1'b0;
            end else begin
               n5_write = 1'b1; n5_read = 1'b0; n5_data = 16'(wseq); wseq++;
            end
            tick();
            if (n5_read) begin
               n_chk++; if (n5_q !== 16'(rexp)) begin n_fail++; $display("FAIL wrap_q[%0d]: got %0d want %0d", rexp, n5_q, rexp); end
               rexp++;
            end
         end
      end
      n5_write = 1'b0; n5_read = 1'b0;
      n_chk++; if (n5_usedw !== 3'd4 || n5_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_usedw: got u=%0d ovf=%b want u=4 ovf=0", n5_usedw, n5_ovf); end
      n_chk++; if (u_n5.r_wrptr !== 3'd2 || u_n5.r_rdptr !== 3'd3) begin n_fail++; $display("FAIL wrap_ptrs: got w=%0d r=%0d want w=2 r=3", u_n5.r_wrptr, u_n5.r_rdptr); end
      for (int i = 0; i < 4; i++) begin
         n5_read = 1'b1;
         tick();
         n_chk++; if (n5_q !== 16'(rexp)) begin n_fail++; $display("FAIL wrap_drain_q[%0d]: got %0d want %0d", rexp, n5_q, rexp); end
         rexp++;
      end
      n5_read = 1'b0;
      n_chk++; if (n5_empty !== 1'b1 || u_n5.r_rdptr !== 3'd2) begin n_fail++; $display("FAIL wrap_end: got e=%b r=%0d want e=1 r=2", n5_empty, u_n5.r_rdptr); end
   endtask

   task automatic test_full_empty_simul();
      for (int i = 0; i < 8; i++) begin
         n8_write = 1'b1; n8_data = 16'(16'h0100 + i);
         tick();
      end
      n8_write = 1'b0;
      n_chk++; if (n8_full !== 1'b1 || n8_usedw !== 4'd8 || n8_afull !== 1'b1) begin n_fail++; $display("FAIL full_state: got f=%b u=%0d af=%b want f=1 u=8 af=1", n8_full, n8_usedw, n8_afull); end
      n8_write = 1'b1; n8_read = 1'b1; n8_data = 16'hDEAD;
      tick();
      n_chk++; if (n8_usedw !== 4'd7 || n8_ovf !== 1'b1 || n8_full !== 1'b0) begin n_fail++; $display("FAIL full_wr_rd: got u=%0d ovf=%b f=%b want u=7 ovf=1 f=0", n8_usedw, n8_ovf, n8_full); end
      n_chk++; if (n8_q !== 16'h0100) begin n_fail++; $display("FAIL full_wr_rd_q: got %h want 0100", n8_q); end
      n8_write = 1'b0;
      for (int i = 1; i < 8; i++) begin
         tick();
         n_chk++; if (n8_q !== 16'(16'h0100 + i)) begin n_fail++; $display("FAIL full_drain_q[%0d]: got %h want %h", i, n8_q, 16'(16'h0100 + i)); end
      end
      n8_read = 1'b0;
      n_chk++; if (n8_empty !== 1'b1 || n8_usedw !== 4'd0 || n8_ovf !== 1'b1) begin n_fail++; $display("FAIL full_drained: got e=%b u=%0d ovf=%b want e=1 u=0 ovf=1", n8_empty, n8_usedw, n8_ovf); end
      n8_write = 1'b1; n8_read = 1'b1; n8_data = 16'h0055;
      tick();
      n8_write = 1'b0; n8_read = 1'b0;
      n_chk++; if (n8_usedw !== 4'd1 || n8_unf !== 1'b1 || n8_empty !== 1'b0) begin n_fail++; $display("FAIL empty_wr_rd: got u=%0d unf=%b e=%b want u=1 unf=1 e=0", n8_usedw, n8_unf, n8_empty); end
      n_chk++; if (n8_q !== 16'h0107) begin n_fail++; $display("FAIL empty_wr_rd_q: got %h want 0107", n8_q); end
      n8_sclr = 1'b1;
      tick();
      n8_sclr = 1'b0;
      n_chk++; if (n8_ovf !== 1'b0 || n8_unf !== 1'b0 || n8_usedw !== 4'd0 || n8_empty !== 1'b1) begin n_fail++; $display("FAIL sclr: got ovf=%b unf=%b u=%0d e=%b want 0 0 0 1", n8_ovf, n8_unf, n8_usedw, n8_empty); end
      n_chk++; if (n8_q !== 16'h0107) begin n_fail++; $display("FAIL sclr_q_hold: got %h want 0107", n8_q); end
   endtask

   task automatic test_showahead_single();
      sa_write = 1'b1; sa_data = 16'h00AB;
      tick();
      sa_write = 1'b0;
      n_chk++; if (sa_usedw !== 4'd1 || sa_empty !== 1'b1) begin n_fail++; $display("FAIL sa_prefetch: got u=%0d e=%b want u=1 e=1", sa_usedw, sa_empty); end
      tick();
      n_chk++; if (sa_empty !== 1'b0 || sa_q !== 16'h00AB || sa_usedw !== 4'd1) begin n_fail++; $display("FAIL sa_visible: got e=%b q=%h u=%0d want e=0 q=00ab u=1", sa_empty, sa_q, sa_usedw); end
      sa_read = 1'b1;
      tick();
      sa_read = 1'b0;
      n_chk++; if (sa_empty !== 1'b1 || sa_usedw !== 4'd0 || sa_unf !== 1'b0) begin n_fail++; $display("FAIL sa_popped: got e=%b u=%0d unf=%b want e=1 u=0 unf=0", sa_empty, sa_usedw, sa_unf); end
   endtask

   task automatic test_showahead_stream();
      int  wcnt = 0;
      int  rcnt = 0;
      int  cyc  = 0;
      bit  started = 1'b0;
      while (rcnt < 16 && cyc < 60) begin
         if (started) begin
            n_chk++; if (sa_empty !== 1'b0) begin n_fail++; $display("FAIL sa_stream_gap: got empty=%b want 0 at word %0d", sa_empty, rcnt + 1); end
         end
         sa_write = (wcnt < 16);
         sa_data  = 16'(wcnt + 1);
         sa_read  = !sa_empty;
         if (sa_read) begin
            n_chk++; if (sa_q !== 16'(rcnt + 1)) begin n_fail++; $display("FAIL sa_stream_q: got %h want %h", sa_q, 16'(rcnt + 1)); end
            rcnt++;
            started = 1'b1;
         end
         if (sa_write) wcnt++;
         tick();
         cyc++;
         n_chk++; if (sa_usedw > 4'd2) begin n_fail++; $display("FAIL sa_stream_usedw: got %0d want <= 2", sa_usedw); end
      end
      sa_write = 1'b0; sa_read = 1'b0;
      n_chk++; if (rcnt != 16) begin n_fail++; $display("FAIL sa_stream_count: got %0d words want 16", rcnt); end
      n_chk++; if (sa_empty !== 1'b1 || sa_usedw !== 4'd0) begin n_fail++; $display("FAIL sa_stream_end: got e=%b u=%0d want e=1 u=0", sa_empty, sa_usedw); end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 6; i++) begin
         n8_write = 1'b1; n8_data = 16'(16'h0060 + i);
         tick();
      end
      n8_write = 1'b0;
      n_chk++; if (n8_usedw !== 4'd6) begin n_fail++; $display("FAIL midop_pre_usedw: got %0d want 6", n8_usedw); end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_chk++; if (n8_usedw !== 4'd0 || n8_empty !== 1'b1 || n8_full !== 1'b0) begin n_fail++; $display("FAIL midop_rst: got u=%0d e=%b f=%b want 0 1 0", n8_usedw, n8_empty, n8_full); end
      n_chk++; if (n8_aempty !== 1'b1 || n8_afull !== 1'b0 || n8_q !== 16'h0 || n8_ovf !== 1'b0 || n8_unf !== 1'b0) begin n_fail++; $display("FAIL midop_rst_flags: got ae=%b af=%b q=%h ovf=%b unf=%b want 1 0 0000 0 0", n8_aempty, n8_afull, n8_q, n8_ovf, n8_unf); end
      @(negedge clk);
      rst = 1'b0;
      n8_write = 1'b1; n8_data = 16'h0077;
      tick();
      n8_write = 1'b0; n8_read = 1'b1;
      tick();
      n8_read = 1'b0;
      n_chk++; if (n8_q !== 16'h0077 || n8_usedw !== 4'd0) begin n_fail++; $display("FAIL midop_after: got q=%h u=%0d want q=0077 u=0", n8_q, n8_usedw); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_normal_fill_drain();
      test_wraparound();
      test_full_empty_simul();
      test_showahead_single();
      test_showahead_stream();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
